// File: rtl/jedro_1_ifu_if.sv
// rtl/jedro_1_ifu_if.sv - jedro_1 fetch bundle: ROM port, decoder handshake, redirect; misaligned_o only with JEDRO_1_IFU_MISALIGN_EXC_EN
interface jedro_1_ifu_if;
    logic        instr_mem_en_o;
    logic [31:0] instr_mem_addr_o;
    logic [31:0] instr_mem_rdata_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic        jmp_i;
    logic [31:0] jmp_addr_i;
`ifdef JEDRO_1_IFU_MISALIGN_EXC_EN
    logic        misaligned_o;
`endif

    modport master (
`ifdef JEDRO_1_IFU_MISALIGN_EXC_EN
        output misaligned_o,
`endif
        output instr_mem_en_o,
        output instr_mem_addr_o,
        input  instr_mem_rdata_i,
        output instr_o,
        output pc_o,
        output instr_valid_o,
        input  instr_ready_i,
        input  jmp_i,
        input  jmp_addr_i
    );

    modport slave (
`ifdef JEDRO_1_IFU_MISALIGN_EXC_EN
        input  misaligned_o,
`endif
        input  instr_mem_en_o,
        input  instr_mem_addr_o,
        output instr_mem_rdata_i,
        input  instr_o,
        input  pc_o,
        input  instr_valid_o,
        output instr_ready_i,
        output jmp_i,
        output jmp_addr_i
    );
endinterface

// File: rtl/jedro_1_ifu.sv
// rtl/jedro_1_ifu.sv - jedro_1 instruction fetch unit with prefetch FIFO; optional macro JEDRO_1_IFU_MISALIGN_EXC_EN
module jedro_1_ifu #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH     = 4
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    jedro_1_ifu_if.master bus
);
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned CW  = AW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,  // first cycle out of reset, no request yet
        ST_RUN      = 2'd1,  // normal fetching
        ST_MISALIGN = 2'd2   // parked on a misaligned jump target
    } state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic [31:0]   r_fpc;
    logic [31:0]   r_rpc;
    logic [31:0]   r_instr;
    logic [31:0]   r_pc;
    logic          r_inflight;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_rptr;
    logic [AW-1:0] r_wptr;
    logic [31:0]   r_mem_instr [DEPTH];
    logic [31:0]   r_mem_pc    [DEPTH];

    logic          w_req;
    logic          w_push;
    logic          w_pop;
    logic          w_bad_target;
    logic [CW-1:0] w_used;
    logic [CW-1:0] w_count_left;
    logic [AW-1:0] w_rptr_next;
    logic [31:0]   w_jmp_target;

    assign w_jmp_target = {bus.jmp_addr_i[31:2], 2'b00};

`ifdef JEDRO_1_IFU_MISALIGN_EXC_EN
    assign w_bad_target     = |bus.jmp_addr_i[1:0];
    assign bus.misaligned_o = (r_state == ST_MISALIGN);
`else
    assign w_bad_target     = 1'b0;
`endif

    // A jump voids any handshake and any returning word in its own cycle
    assign w_used       = r_count + CW'(r_inflight);
    assign w_pop        = (r_count != '0) && bus.instr_ready_i && !bus.jmp_i;
    assign w_push       = r_inflight && !bus.jmp_i;
    assign w_count_left = r_count - CW'(w_pop);
    assign w_rptr_next  = r_rptr + AW'(w_pop);

    assign bus.instr_mem_en_o   = w_req;
    assign bus.instr_mem_addr_o = r_fpc;
    assign bus.instr_o          = r_instr;
    assign bus.pc_o             = r_pc;
    assign bus.instr_valid_o    = (r_count != '0);

    // Next state and request decision: request only while running, outside a jump, with a free credit
    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        if (bus.jmp_i) begin
            w_state_next = w_bad_target ? ST_MISALIGN : ST_RUN;
        end else if (r_state == ST_IDLE) begin
            w_state_next = ST_RUN;
        end
        if ((r_state == ST_RUN) && !bus.jmp_i && (w_used < CW'(DEPTH))) begin
            w_req = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Prefetch storage, written with the returning word and its address
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem_instr[r_wptr] <= bus.instr_mem_rdata_i;
            r_mem_pc[r_wptr]    <= r_rpc;
        end
    end

    // Fetch PC, response tracking, FIFO bookkeeping and the registered head
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_fpc      <= BOOT_ADDR;
            r_rpc      <= BOOT_ADDR;
            r_inflight <= 1'b0;
            r_count    <= '0;
            r_rptr     <= '0;
            r_wptr     <= '0;
            r_instr    <= NOP;
            r_pc       <= BOOT_ADDR;
        end else if (bus.jmp_i) begin
            r_fpc      <= w_jmp_target;
            r_inflight <= 1'b0;
            r_count    <= '0;
            r_rptr     <= '0;
            r_wptr     <= '0;
        end else begin
            r_inflight <= w_req;
            if (w_req) begin
                r_fpc <= r_fpc + 32'd4;
                r_rpc <= r_fpc;
            end
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            r_rptr  <= w_rptr_next;
            r_count <= w_count_left + CW'(w_push);
            // Head after this edge: an older entry if one survives the pop, else the word arriving now
            if (w_count_left != '0) begin
                r_instr <= r_mem_instr[w_rptr_next];
                r_pc    <= r_mem_pc[w_rptr_next];
            end else if (w_push) begin
                r_instr <= bus.instr_mem_rdata_i;
                r_pc    <= r_rpc;
            end
        end
    end
endmodule

// File: doc/jedro_1_ifu.md
# jedro_1_ifu

Instruction fetch unit for the jedro_1 core. It generates sequential word addresses to the instruction ROM, which has a fixed 1-cycle read latency. Returned words are buffered in a small prefetch FIFO, and each instruction and its PC are handed to the decoder over a valid/ready handshake. Taken jumps and branches redirect it through a single-cycle flush, which discards all buffered and in-flight words.

## Interface
- `BOOT_ADDR`, default 32'h0000_0000: PC fetched first after reset.
- `DEPTH`, default 4: prefetch FIFO entries; power of two, minimum 2.
- `clk_i` in 1: clock.
- `rstn_i` in 1: reset, asynchronous and active-low.
- `instr_mem_en_o` out 1: ROM read request this cycle.
- `instr_mem_addr_o` out 32: byte address of the request, word aligned.
- `instr_mem_rdata_i` in 32: ROM data, valid one cycle after a request.
- `instr_o` out 32: instruction at the FIFO head.
- `pc_o` out 32: address of `instr_o`.
- `instr_valid_o` out 1: the FIFO head is valid.
- `instr_ready_i` in 1: decoder accepts the head this cycle.
- `jmp_i` in 1: redirect the fetch stream (single-cycle pulse).
- `jmp_addr_i` in 32: redirect target.
- `misaligned_o` out 1: misaligned jump target detected. Present only under the macro; see Configuration.

## Operation
- Fetch PC register `fpc`. Reset value is `BOOT_ADDR`. It advances by 4 on every issued request.
- Credit rule: issue a request (`instr_mem_en_o`=1, `instr_mem_addr_o`=`fpc`) when `count + inflight < DEPTH`. Here `inflight` is a 1-bit flag set by a request and cleared when its data returns.
- Response path: a cycle after the request, `instr_mem_rdata_i` and the PC register `rpc` (= the request address) are pushed into the FIFO, unless that response has been killed.
- Pop: `instr_valid_o && instr_ready_i` removes the head.
- Push and pop in the same cycle keeps `count` unchanged. Credits guarantee a push never happens when the FIFO is full.
- Empty FIFO: `instr_valid_o`=0. `instr_o` and `pc_o` hold their last values, but the decoder must ignore them.
- Flush, when `jmp_i`=1:
  - `count` goes to 0; read and write pointers go to 0.
  - Any response arriving in the next cycle is killed.
  - `fpc` is loaded with `{jmp_addr_i[31:2],2'b00}`.
  - No request is issued in the `jmp_i` cycle.
  - Flush has priority over push and pop in the same cycle. A handshake in that cycle is void: the decoder is also flushed.
- Pointer wrap-around: the pointers are log2(DEPTH) bits and wrap naturally. `count` is log2(DEPTH)+1 bits.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 0. No fault is raised.

## Timing
- Reset values:
  - `instr_mem_en_o`=0
  - `instr_mem_addr_o`=`BOOT_ADDR`
  - `instr_valid_o`=0
  - `instr_o`=32'h0000_0013 (NOP)
  - `pc_o`=`BOOT_ADDR`
  - `misaligned_o`=0
  - `count`=0, `inflight`=0
- Reset deasserting in cycle R: the first request is in cycle R+1, and `instr_valid_o` rises in R+3.
  - The registered response capture takes the R+2 edge.
  - The FIFO output is registered.
- Steady state: with `instr_ready_i` held at 1 and no jumps, one instruction per cycle. PCs are consecutive.
- Jump in cycle J: the request to the target goes out in J+1, and the first valid target instruction appears in J+3. `instr_valid_o` is 0 in J+1 and J+2.
- Back-to-back jumps: each one restarts the sequence. The last jump wins.
- Asynchronous reset mid-operation: all state returns to its reset value immediately. No partial instruction is delivered after reset.
- `instr_ready_i` may change freely. `instr_o` and `pc_o` must remain stable while `instr_valid_o`=1 and `instr_ready_i`=0.

## Configuration
- Macro `JEDRO_1_IFU_MISALIGN_EXC_EN`.
- Defined:
  - A jump with `jmp_addr_i[1:0]` != 0 sets `misaligned_o`=1 from J+1.
  - Fetching is suppressed: no requests are issued and `instr_valid_o`=0.
  - Both remain so until the next jump with an aligned target, which clears `misaligned_o` and resumes normal operation.
- Not defined:
  - The `misaligned_o` port is absent.
  - The low two bits of `jmp_addr_i` are silently zeroed.

## Test plan
- Reset release, ROM holding `addi x1,x0,1` at 0x0, `instr_ready_i`=1 -> `instr_valid_o` rises 3 cycles later with `instr_o`=32'h00100093 and `pc_o`=0. Subsequent PCs are 4, 8, 12 on consecutive cycles.
- `instr_ready_i`=0 for 10 cycles -> exactly `DEPTH` (4) requests are issued, then `instr_mem_en_o` stays 0. Raising ready drains PCs 0, 4, 8, 12 in order, then fetching resumes at 16.
- `jmp_i` with `jmp_addr_i`=0x40 while the FIFO holds 3 entries and one request is in flight -> no instruction with PC 0x10 or 0x14 is delivered. The next valid instruction has `pc_o`=0x40, three cycles after the jump.
- Jumps on two consecutive cycles to 0x80 then 0xC0 -> the first valid `pc_o` is 0xC0. 0x80 never appears.
- `rstn_i` pulled low asynchronously between clock edges with 2 entries buffered -> `instr_valid_o`=0 immediately. After release, fetching restarts at `BOOT_ADDR`.
- With `JEDRO_1_IFU_MISALIGN_EXC_EN`: jump to 0x42 -> `misaligned_o`=1 and no requests. A following jump to 0x48 -> `misaligned_o`=0 and `pc_o`=0x48 valid 3 cycles later. Without the macro: a jump to 0x42 delivers `pc_o`=0x40.
